plab5_mcore_proc_resp_arb_secure: RTL and testbench
===================================================

PLAB5_MCORE_PROC_RESP_ARB_SECURE -- requirements
Module: plab5_mcore_proc_resp_arb_secure

Interface
REQ-001 SHALL have parameter p_opaque_nbits, default 8, memory response opaque field width.
REQ-002 SHALL have parameter p_data_nbits, default 32, memory response data width.
REQ-003 SHALL derive local resp_nbits = `VC_MEM_RESP_MSG_NBITS(p_opaque_nbits,p_data_nbits)`, which is 45 at defaults.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 proc_sec_level  input  1  security level of the processor: 0 = low, 1 = high.
REQ-008 in0_val / in0_rdy / in0_msg  in / out / in  1 / 1 / resp_nbits  memory-network response port.
REQ-009 in0_sec_level  input  1  security level of the in0 response.
REQ-010 in1_val / in1_rdy / in1_msg  in / out / in  1 / 1 / resp_nbits  accelerator response port.
REQ-011 in1_sec_level  input  1  security level of the in1 response.
REQ-012 proc_resp_val / proc_resp_rdy / proc_resp_msg  out / in / out  1 / 1 / resp_nbits  processor response port.
REQ-013 drop_count  output  8  saturating count of dropped responses.

Function
REQ-014 A transfer on any port SHALL occur only on a cycle where val && rdy at a rising clk edge.
REQ-015 One-entry output buffer SHALL hold {msg, sec_level}; states EMPTY and FULL.
REQ-016 proc_resp_val SHALL be 1 iff state is FULL and the stored sec_level <= proc_sec_level, evaluated in the current cycle.
REQ-017 proc_resp_msg SHALL be driven from the buffer register only, with no combinational input-to-output path; latency is 1 cycle from input transfer to proc_resp_val.
REQ-018 Eligible candidate: input with val = 1.
REQ-019 The arbiter SHALL grant at most one eligible candidate per cycle, using round-robin priority; the priority pointer resets to in0.
REQ-020 A grant SHALL be a "drop" if the input's sec_level > proc_sec_level; otherwise it is a "deliver".
REQ-021 A drop grant SHALL assert in_rdy regardless of buffer state, SHALL NOT load the buffer, and SHALL increment drop_count.
REQ-022 A deliver grant SHALL assert in_rdy only if the buffer is EMPTY or a proc transfer occurs this cycle; the entry is loaded at the edge and the state is FULL.
REQ-023 If the deliver candidate cannot be accepted, no in_rdy SHALL assert and the pointer SHALL be unchanged.
REQ-024 The priority pointer SHALL move to the other input after every accepted input transfer, whether drop or deliver.
REQ-025 FULL->EMPTY SHALL occur on a proc transfer with no same-cycle load; a proc transfer with a same-cycle load SHALL keep the state FULL with the new entry.
REQ-026 Flush: if FULL and stored sec_level > proc_sec_level (proc_sec_level lowered while holding), proc_resp_val SHALL be 0, the entry SHALL be cleared at the next edge (state EMPTY), and drop_count SHALL increment.
REQ-027 A cycle with a flush SHALL count as buffer-free for a same-cycle deliver grant.
REQ-028 An in-drop and a flush in the same cycle SHALL add 2 to drop_count.
REQ-029 drop_count SHALL saturate at 255 and never wrap.
REQ-030 in_rdy SHALL be 0 for any input with val = 0.
REQ-031 in0_rdy and in1_rdy SHALL never both be 1 in the same cycle.

Reset
REQ-032 While reset = 0, the block SHALL hold state EMPTY, proc_resp_val = 0, proc_resp_msg = 0, drop_count = 0, priority pointer = in0, and in0_rdy = in1_rdy = 0.
REQ-033 Reset asserted mid-operation SHALL discard the buffered entry without counting it as dropped.
REQ-034 The first transfer SHALL be possible in the first cycle after reset deasserts.

Structure
REQ-035 Security level encodings (SEC_LOW = 0, SEC_HIGH = 1) and the drop counter width (8) SHALL live in the shared header plab5-mcore-sec-levels.v.
REQ-036 The 2-input round-robin arbiter SHALL be sub-module plab5_mcore_rr_arb2, with inputs reqs[1:0] and advance, and output grants[1:0].
REQ-037 The buffer, state register, flush logic and counter SHALL reside in this module.

Verification
REQ-038 Scenario: proc_sec_level = 0, in0 valid with sec 0 and msg data 0x11, proc_resp_rdy = 1 -> next cycle proc_resp_val = 1 with data 0x11; drop_count = 0.
REQ-039 Scenario: both inputs valid with sec 0 every cycle, data A0 and B0, proc always ready -> output order A, B, A, B; in0 wins first after reset.
REQ-040 Scenario: proc_sec_level = 0, in1 valid with sec 1, buffer FULL and proc_resp_rdy = 0 -> in1_rdy = 1 the same cycle, buffer unchanged, drop_count = 1.
REQ-041 Scenario: proc_sec_level = 1, load an entry with sec 1 and proc_resp_rdy = 0, then set proc_sec_level = 0 -> proc_resp_val = 0 that cycle; next cycle state EMPTY and drop_count incremented.
REQ-042 Scenario: 300 consecutive sec-1 responses while proc_sec_level = 0 -> drop_count = 255 and proc_resp_val never asserts.
REQ-043 Scenario: reset asserted with the buffer FULL and drop_count = 5 -> immediately proc_resp_val = 0 and drop_count = 0, and the buffered entry is never delivered.

Source files
------------

// File: rtl/plab5_mcore_proc_resp_arb_secure_pkg.sv
// rtl/plab5_mcore_proc_resp_arb_secure_pkg.sv - security levels, counter width and response message sizing
package plab5_mcore_proc_resp_arb_secure_pkg;

  // Security level encodings shared by processor and response sources
  localparam logic SEC_LOW  = 1'b0;
  localparam logic SEC_HIGH = 1'b1;

  // Width of the saturating dropped-response counter
  localparam int DROP_CNT_NBITS = 8;

  // Memory response layout: {type, opaque, len, data}
  localparam int MEM_RESP_TYPE_NBITS = 3;
  localparam int MEM_RESP_LEN_NBITS  = 2;

  function automatic int mem_resp_msg_nbits(input int opaque_nbits, input int data_nbits);
    return MEM_RESP_TYPE_NBITS + opaque_nbits + MEM_RESP_LEN_NBITS + data_nbits;
  endfunction

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/plab5_mcore_rr_arb2.sv
// rtl/plab5_mcore_rr_arb2.sv - two-input round-robin arbiter with explicit advance
module plab5_mcore_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] reqs,
  input  logic       advance,
  output logic [1:0] grants
);

  // ptr_q = 0 gives in0 priority, 1 gives in1 priority
  logic ptr_q;
  logic ptr_d;

  // Grant the prioritised requester, otherwise the other one if it requests
  always_comb begin
    grants = 2'b00;
    if (ptr_q == 1'b0) begin
      if (reqs[0])      grants = 2'b01;
      else if (reqs[1]) grants = 2'b10;
    end else begin
      if (reqs[1])      grants = 2'b10;
      else if (reqs[0]) grants = 2'b01;
    end
  end

  // After an accepted transfer, priority passes to the input that was not served
  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = grants[0];
  end

  // Priority pointer register, in0 first out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/plab5_mcore_proc_resp_arb_secure.sv
// rtl/plab5_mcore_proc_resp_arb_secure.sv - security-filtered response arbiter feeding the processor
module plab5_mcore_proc_resp_arb_secure
  import plab5_mcore_proc_resp_arb_secure_pkg::*;
#(
  parameter  int p_opaque_nbits = 8,
  parameter  int p_data_nbits   = 32,
  localparam int resp_nbits     = mem_resp_msg_nbits(p_opaque_nbits, p_data_nbits)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      proc_sec_level,
  input  logic                      in0_val,
  output logic                      in0_rdy,
  input  logic [resp_nbits-1:0]     in0_msg,
  input  logic                      in0_sec_level,
  input  logic                      in1_val,
  output logic                      in1_rdy,
  input  logic [resp_nbits-1:0]     in1_msg,
  input  logic                      in1_sec_level,
  output logic                      proc_resp_val,
  input  logic                      proc_resp_rdy,
  output logic [resp_nbits-1:0]     proc_resp_msg,
  output logic [DROP_CNT_NBITS-1:0] drop_count
);

  buf_state_e                state_q, state_d;
  logic [resp_nbits-1:0]     msg_q, msg_d;
  logic                      sec_q, sec_d;
  logic [DROP_CNT_NBITS-1:0] drop_q, drop_d;

  logic [1:0]                grants;
  logic                      flush, proc_xfer, buf_free;
  logic                      sel_sec, in_drop, accept, load;
  logic [resp_nbits-1:0]     sel_msg;
  logic [1:0]                drop_inc;
  logic [DROP_CNT_NBITS:0]   drop_sum;

  plab5_mcore_rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .reqs    ({in1_val, in0_val}),
    .advance (accept),
    .grants  (grants)
  );

  // Output side: an entry above the current processor level is hidden and flushed
  always_comb begin
    flush         = (state_q == BUF_FULL) && (sec_q > proc_sec_level);
    proc_resp_val = (state_q == BUF_FULL) && !flush;
    proc_xfer     = proc_resp_val && proc_resp_rdy;
    buf_free      = (state_q == BUF_EMPTY) || proc_xfer || flush;
    proc_resp_msg = msg_q;
    drop_count    = drop_q;
  end

  // Input side: drops are always taken, deliveries only when the buffer frees up
  always_comb begin
    sel_sec = grants[1] ? in1_sec_level : in0_sec_level;
    sel_msg = grants[1] ? in1_msg : in0_msg;
    in_drop = (|grants) && (sel_sec > proc_sec_level);
    accept  = reset && (|grants) && (in_drop || buf_free);
    load    = accept && !in_drop;
    in0_rdy = accept && grants[0];
    in1_rdy = accept && grants[1];
  end

  // Buffer next state and saturating drop counter (in-drop and flush may add 2)
  always_comb begin
    state_d  = state_q;
    msg_d    = msg_q;
    sec_d    = sec_q;
    if (load) begin
      state_d = BUF_FULL;
      msg_d   = sel_msg;
      sec_d   = sel_sec;
    end else if (proc_xfer || flush) begin
      state_d = BUF_EMPTY;
      msg_d   = '0;
      sec_d   = SEC_LOW;
    end
    drop_inc = {1'b0, in_drop && accept} + {1'b0, flush};
    drop_sum = {1'b0, drop_q} + (DROP_CNT_NBITS+1)'(drop_inc);
    drop_d   = drop_sum[DROP_CNT_NBITS] ? '1 : drop_sum[DROP_CNT_NBITS-1:0];
  end

  // State registers; reset discards any held entry without counting it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BUF_EMPTY;
      msg_q   <= '0;
      sec_q   <= SEC_LOW;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      sec_q   <= sec_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_plab5_mcore_proc_resp_arb_secure.sv
// tb/tb_plab5_mcore_proc_resp_arb_secure.sv - scoreboard bench for the secure response arbiter
module tb_plab5_mcore_proc_resp_arb_secure;

  localparam int RN = 45;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          proc_sec_level = 1'b0;
  logic          in0_val = 1'b0, in0_sec_level = 1'b0;
  logic          in1_val = 1'b0, in1_sec_level = 1'b0;
  logic [RN-1:0] in0_msg = '0, in1_msg = '0;
  logic          in0_rdy, in1_rdy;
  logic          proc_resp_val;
  logic          proc_resp_rdy = 1'b0;
  logic [RN-1:0] proc_resp_msg;
  logic [7:0]    drop_count;

  int            checks = 0;
  int            errors = 0;
  logic [RN-1:0] sb[$];
  logic [RN-1:0] exp_msg;

  plab5_mcore_proc_resp_arb_secure dut (
    .clk            (clk),
    .reset          (reset),
    .proc_sec_level (proc_sec_level),
    .in0_val        (in0_val),
    .in0_rdy        (in0_rdy),
    .in0_msg        (in0_msg),
    .in0_sec_level  (in0_sec_level),
    .in1_val        (in1_val),
    .in1_rdy        (in1_rdy),
    .in1_msg        (in1_msg),
    .in1_sec_level  (in1_sec_level),
    .proc_resp_val  (proc_resp_val),
    .proc_resp_rdy  (proc_resp_rdy),
    .proc_resp_msg  (proc_resp_msg),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [RN-1:0] mk(input logic [7:0] opq, input logic [31:0] data);
    return {3'd0, opq, 2'd0, data};
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    in0_val = 1'b0; in1_val = 1'b0;
    in0_sec_level = 1'b0; in1_sec_level = 1'b0;
    proc_sec_level = 1'b0; proc_resp_rdy = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in0_val = 1'b1; in1_val = 1'b1; proc_resp_rdy = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (proc_resp_val !== 1'b0) begin errors++; $display("FAIL reset_val: got %b want 0", proc_resp_val); end
    checks++; if (proc_resp_msg !== '0) begin errors++; $display("FAIL reset_msg: got %h want 0", proc_resp_msg); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    checks++; if (in0_rdy !== 1'b0) begin errors++; $display("FAIL reset_in0_rdy: got %b want 0", in0_rdy); end
    checks++; if (in1_rdy !== 1'b0) begin errors++; $display("FAIL reset_in1_rdy: got %b want 0", in1_rdy); end
    in0_val = 1'b0; in1_val = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_basic();
    proc_sec_level = 1'b0; proc_resp_rdy = 1'b1;
    in0_val = 1'b1; in0_sec_level = 1'b0; in0_msg = mk(8'h01, 32'h11);
    sb.push_back(in0_msg);
    @(negedge clk);
    checks++; if (in0_rdy !== 1'b1) begin errors++; $display("FAIL basic_first_rdy: got %b want 1", in0_rdy); end
    @(posedge clk); #1 in0_val = 1'b0;
    @(negedge clk);
    exp_msg = sb.pop_front();
    checks++; if (proc_resp_val !== 1'b1) begin errors++; $display("FAIL basic_val: got %b want 1", proc_resp_val); end
    checks++; if (proc_resp_msg !== exp_msg) begin errors++; $display("FAIL basic_msg: got %h want %h", proc_resp_msg, exp_msg); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL basic_drop: got %0d want 0", drop_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] n0, n1;
    logic        exp0;
    apply_reset();
    n0 = 32'd0; n1 = 32'd0;
    proc_resp_rdy = 1'b1;
    in0_val = 1'b1; in1_val = 1'b1;
    in0_msg = mk(8'h00, 32'hA0); in1_msg = mk(8'h01, 32'hB0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp0 = (c % 2 == 0);
      checks++;
      if (in0_rdy !== exp0 || in1_rdy !== !exp0) begin
        errors++; $display("FAIL rr_grant c=%0d: in0_rdy=%b in1_rdy=%b want %b %b", c, in0_rdy, in1_rdy, exp0, !exp0);
      end
      if (c > 0) begin
        exp_msg = sb.pop_front();
        checks++;
        if (proc_resp_val !== 1'b1 || proc_resp_msg !== exp_msg) begin
          errors++; $display("FAIL rr_out c=%0d: val=%b msg=%h want 1 %h", c, proc_resp_val, proc_resp_msg, exp_msg);
        end
      end
      sb.push_back(exp0 ? in0_msg : in1_msg);
      @(posedge clk); #1;
      if (exp0) begin n0 = n0 + 32'd1; in0_msg = mk(8'h00, 32'hA0 + n0); end
      else      begin n1 = n1 + 32'd1; in1_msg = mk(8'h01, 32'hB0 + n1); end
    end
    in0_val = 1'b0; in1_val = 1'b0;
    @(negedge clk);
    exp_msg = sb.pop_front();
    checks++;
    if (proc_resp_val !== 1'b1 || proc_resp_msg !== exp_msg) begin
      errors++; $display("FAIL rr_last: val=%b msg=%h want 1 %h", proc_resp_val, proc_resp_msg, exp_msg);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall_and_drop();
    proc_sec_level = 1'b0; proc_resp_rdy = 1'b0;
    in0_val = 1'b1; in0_sec_level = 1'b0; in0_msg = mk(8'h02, 32'h22);
    sb.push_back(in0_msg);
    @(negedge clk);
    checks++; if (in0_rdy !== 1'b1) begin errors++; $display("FAIL stall_load_rdy: got %b want 1", in0_rdy); end
    @(posedge clk); #1 in0_msg = mk(8'h02, 32'h23);
    @(negedge clk);
    checks++; if (in0_rdy !== 1'b0) begin errors++; $display("FAIL stall_blocked_rdy: got %b want 0", in0_rdy); end
    checks++; if (proc_resp_val !== 1'b1 || proc_resp_msg !== sb[0]) begin errors++; $display("FAIL stall_hold: val=%b msg=%h want 1 %h", proc_resp_val, proc_resp_msg, sb[0]); end
    @(posedge clk); #1;
    in0_val = 1'b0;
    in1_val = 1'b1; in1_sec_level = 1'b1; in1_msg = mk(8'h03, 32'h33);
    @(negedge clk);
    checks++; if (in1_rdy !== 1'b1) begin errors++; $display("FAIL drop_rdy_when_full: got %b want 1", in1_rdy); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL drop_before: got %0d want 0", drop_count); end
    @(posedge clk); #1 in1_val = 1'b0;
    @(negedge clk);
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL drop_count_one: got %0d want 1", drop_count); end
    checks++; if (proc_resp_val !== 1'b1 || proc_resp_msg !== sb[0]) begin errors++; $display("FAIL drop_buf_unchanged: val=%b msg=%h want 1 %h", proc_resp_val, proc_resp_msg, sb[0]); end
    @(posedge clk); #1;
    proc_resp_rdy = 1'b1;
    in0_val = 1'b1; in0_sec_level = 1'b0;
    @(negedge clk);
    checks++; if (in0_rdy !== 1'b1) begin errors++; $display("FAIL passthru_rdy: got %b want 1", in0_rdy); end
    exp_msg = sb.pop_front();
    checks++; if (proc_resp_val !== 1'b1 || proc_resp_msg !== exp_msg) begin errors++; $display("FAIL passthru_out: val=%b msg=%h want 1 %h", proc_resp_val, proc_resp_msg, exp_msg); end
    sb.push_back(in0_msg);
    @(posedge clk); #1 in0_val = 1'b0;
    @(negedge clk);
    exp_msg = sb.pop_front();
    checks++; if (proc_resp_val !== 1'b1 || proc_resp_msg !== exp_msg) begin errors++; $display("FAIL passthru_second: val=%b msg=%h want 1 %h", proc_resp_val, proc_resp_msg, exp_msg); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (proc_resp_val !== 1'b0) begin errors++; $display("FAIL drained_val: got %b want 0", proc_resp_val); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    proc_sec_level = 1'b1; proc_resp_rdy = 1'b0;
    in0_val = 1'b1; in0_sec_level = 1'b1; in0_msg = mk(8'h04, 32'h44);
    @(posedge clk); #1 in0_val = 1'b0;
    @(negedge clk);
    checks++; if (proc_resp_val !== 1'b1 || proc_resp_msg !== mk(8'h04, 32'h44)) begin errors++; $display("FAIL flush_held: val=%b msg=%h", proc_resp_val, proc_resp_msg); end
    @(posedge clk); #1 proc_sec_level = 1'b0;
    @(negedge clk);
    checks++; if (proc_resp_val !== 1'b0) begin errors++; $display("FAIL flush_val_hidden: got %b want 0", proc_resp_val); end
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL flush_drop_before: got %0d want 1", drop_count); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL flush_drop_after: got %0d want 2", drop_count); end
    checks++; if (proc_resp_val !== 1'b0 || proc_resp_msg !== '0) begin errors++; $display("FAIL flush_cleared: val=%b msg=%h want 0 0", proc_resp_val, proc_resp_msg); end
    @(posedge clk); #1;
    proc_sec_level = 1'b1;
    in0_val = 1'b1; in0_sec_level = 1'b1; in0_msg = mk(8'h04, 32'h45);
    @(posedge clk); #1;
    proc_sec_level = 1'b0;
    in0_sec_level = 1'b0; in0_msg = mk(8'h05, 32'h55);
    sb.push_back(in0_msg);
    @(negedge clk);
    checks++; if (in0_rdy !== 1'b1) begin errors++; $display("FAIL flush_frees_buffer: in0_rdy=%b want 1", in0_rdy); end
    @(posedge clk); #1 in0_val = 1'b0;
    @(negedge clk);
    checks++; if (drop_count !== 8'd3) begin errors++; $display("FAIL flush_deliver_drop: got %0d want 3", drop_count); end
    exp_msg = sb.pop_front();
    checks++; if (proc_resp_val !== 1'b1 || proc_resp_msg !== exp_msg) begin errors++; $display("FAIL flush_deliver_out: val=%b msg=%h want 1 %h", proc_resp_val, proc_resp_msg, exp_msg); end
    @(posedge clk); #1 proc_resp_rdy = 1'b1;
    @(posedge clk); #1;
    proc_resp_rdy = 1'b0; proc_sec_level = 1'b1;
    in0_val = 1'b1; in0_sec_level = 1'b1; in0_msg = mk(8'h06, 32'h66);
    @(posedge clk); #1;
    in0_val = 1'b0; proc_sec_level = 1'b0;
    in1_val = 1'b1; in1_sec_level = 1'b1; in1_msg = mk(8'h07, 32'h77);
    @(negedge clk);
    checks++; if (in1_rdy !== 1'b1 || proc_resp_val !== 1'b0) begin errors++; $display("FAIL double_drop_cycle: in1_rdy=%b val=%b want 1 0", in1_rdy, proc_resp_val); end
    @(posedge clk); #1 in1_val = 1'b0;
    @(negedge clk);
    checks++; if (drop_count !== 8'd5) begin errors++; $display("FAIL double_drop_count: got %0d want 5", drop_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    apply_reset();
    proc_sec_level = 1'b0; proc_resp_rdy = 1'b1;
    in1_val = 1'b1; in1_sec_level = 1'b1; in1_msg = mk(8'h09, 32'h99);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      checks++;
      if (proc_resp_val !== 1'b0 || in1_rdy !== 1'b1) begin
        errors++; $display("FAIL sat_cycle c=%0d: val=%b in1_rdy=%b want 0 1", c, proc_resp_val, in1_rdy);
      end
      if (c == 200) begin
        checks++; if (drop_count !== 8'd200) begin errors++; $display("FAIL sat_mid: got %0d want 200", drop_count); end
      end
      @(posedge clk); #1;
    end
    in1_val = 1'b0;
    @(negedge clk);
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL sat_final: got %0d want 255", drop_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    proc_sec_level = 1'b0; proc_resp_rdy = 1'b0;
    in1_val = 1'b1; in1_sec_level = 1'b1; in1_msg = mk(8'h0a, 32'hAA);
    repeat (5) @(posedge clk);
    #1 in1_val = 1'b0;
    in0_val = 1'b1; in0_sec_level = 1'b0; in0_msg = mk(8'h08, 32'h88);
    @(posedge clk); #1 in0_val = 1'b0;
    @(negedge clk);
    checks++; if (drop_count !== 8'd5 || proc_resp_val !== 1'b1) begin errors++; $display("FAIL pre_reset: drop=%0d val=%b want 5 1", drop_count, proc_resp_val); end
    #2 reset = 1'b0;
    #1;
    checks++; if (proc_resp_val !== 1'b0) begin errors++; $display("FAIL async_reset_val: got %b want 0", proc_resp_val); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL async_reset_drop: got %0d want 0", drop_count); end
    checks++; if (proc_resp_msg !== '0) begin errors++; $display("FAIL async_reset_msg: got %h want 0", proc_resp_msg); end
    @(posedge clk); #1 reset = 1'b1; proc_resp_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (proc_resp_val !== 1'b0 || drop_count !== 8'd0) begin errors++; $display("FAIL post_reset c=%0d: val=%b drop=%0d want 0 0", c, proc_resp_val, drop_count); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall_and_drop();
    test_flush();
    test_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
